// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: funct3 codes, counter states
// and the branch-direction helpers used by the top level.
package branch_predictor_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic resolve_taken(input logic [2:0] f3, input logic lt, input logic zero);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = !zero;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = !lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
import branch_predictor_pkg::*;

module bp_sat_counter (
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        case (ctr)
            SNT:     ctr_next = taken ? WNT : SNT;
            WNT:     ctr_next = taken ? WT  : SNT;
            WT:      ctr_next = taken ? ST  : WNT;
            ST:      ctr_next = taken ? ST  : WT;
            default: ctr_next = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction, training
// from resolved branches and a registered flush/redirect on mispredict.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] fetch_pc_in,
    output logic        pred_taken_out,
    output logic [31:0] pred_target_out,
    input  logic        upd_valid_in,
    input  logic [31:0] upd_pc_in,
    input  logic [2:0]  upd_funct3_in,
    input  logic        upd_lt_in,
    input  logic        upd_zero_in,
    input  logic [31:0] upd_target_in,
    input  logic        upd_pred_taken_in,
    input  logic [31:0] upd_pred_target_in,
    output logic        flush_out,
    output logic [31:0] redirect_pc_out
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches_out,
    output logic [31:0] stat_mispred_out
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  valid_q;
    ctr_t              ctr_q    [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [31:0]       target_q [DEPTH];

    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_hit;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_legal;
    logic              actual_taken;
    logic              mispredict;
    ctr_t              ctr_next;

    logic              unused_pc_bits;

    assign unused_pc_bits = ^fetch_pc_in[1:0];

    assign fetch_idx = fetch_pc_in[IDX_W+1:2];
    assign fetch_tag = fetch_pc_in[IDX_W+1+TAG_W:IDX_W+2];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // Lookup reads the registered table only, so a same-index update is not bypassed.
    always_comb begin
        pred_taken_out  = 1'b0;
        pred_target_out = 32'd0;
        if (fetch_hit) begin
            pred_taken_out  = ctr_q[fetch_idx][1];
            pred_target_out = target_q[fetch_idx];
        end
    end

    assign upd_idx      = upd_pc_in[IDX_W+1:2];
    assign upd_tag      = upd_pc_in[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_legal    = upd_valid_in && f3_legal(upd_funct3_in);
    assign actual_taken = resolve_taken(upd_funct3_in, upd_lt_in, upd_zero_in);
    assign mispredict   = (actual_taken != upd_pred_taken_in) ||
                          (actual_taken && (upd_pred_target_in != upd_target_in));

    bp_sat_counter u_sat_counter (
        .ctr      (ctr_q[upd_idx]),
        .taken    (actual_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_legal) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
            end else if (actual_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= WT;
            end
        end
    end

    // Tags and targets are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (upd_legal && actual_taken) begin
            target_q[upd_idx] <= upd_target_in;
            if (!upd_hit) begin
                tag_q[upd_idx] <= upd_tag;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            flush_out       <= 1'b0;
            redirect_pc_out <= 32'd0;
        end else begin
            flush_out <= upd_legal && mispredict;
            if (upd_legal) begin
                redirect_pc_out <= actual_taken ? upd_target_in : (upd_pc_in + 32'd4);
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_branches_out <= 32'd0;
            stat_mispred_out  <= 32'd0;
        end else if (upd_legal) begin
            stat_branches_out <= stat_branches_out + 32'd1;
            if (mispredict) begin
                stat_mispred_out <= stat_mispred_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: reset, training, counter
// saturation, direction decode, aliasing, illegal funct3 and mid-run reset.
module tb_branch_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] fetch_pc_in;
    logic        pred_taken_out;
    logic [31:0] pred_target_out;
    logic        upd_valid_in;
    logic [31:0] upd_pc_in;
    logic [2:0]  upd_funct3_in;
    logic        upd_lt_in;
    logic        upd_zero_in;
    logic [31:0] upd_target_in;
    logic        upd_pred_taken_in;
    logic [31:0] upd_pred_target_in;
    logic        flush_out;
    logic [31:0] redirect_pc_out;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches_out;
    logic [31:0] stat_mispred_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    branch_predictor dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .fetch_pc_in        (fetch_pc_in),
        .pred_taken_out     (pred_taken_out),
        .pred_target_out    (pred_target_out),
        .upd_valid_in       (upd_valid_in),
        .upd_pc_in          (upd_pc_in),
        .upd_funct3_in      (upd_funct3_in),
        .upd_lt_in          (upd_lt_in),
        .upd_zero_in        (upd_zero_in),
        .upd_target_in      (upd_target_in),
        .upd_pred_taken_in  (upd_pred_taken_in),
        .upd_pred_target_in (upd_pred_target_in),
        .flush_out          (flush_out),
        .redirect_pc_out    (redirect_pc_out)
`ifdef BP_STATS_EN
        ,
        .stat_branches_out  (stat_branches_out),
        .stat_mispred_out   (stat_mispred_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one update at the falling edge and returns just after the rising edge.
    task automatic apply_update(input logic [31:0] pc, input logic [2:0] f3, input logic lt,
                                input logic zero, input logic [31:0] target,
                                input logic pt, input logic [31:0] ptarget);
        @(negedge clk_in);
        upd_valid_in       = 1'b1;
        upd_pc_in          = pc;
        upd_funct3_in      = f3;
        upd_lt_in          = lt;
        upd_zero_in        = zero;
        upd_target_in      = target;
        upd_pred_taken_in  = pt;
        upd_pred_target_in = ptarget;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk_in);
        upd_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_target);
        fetch_pc_in = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken_out}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target_out, exp_target);
    endtask

    initial begin
        rst_in             = 1'b1;
        fetch_pc_in        = 32'h100;
        upd_valid_in       = 1'b0;
        upd_pc_in          = 32'd0;
        upd_funct3_in      = 3'b000;
        upd_lt_in          = 1'b0;
        upd_zero_in        = 1'b0;
        upd_target_in      = 32'd0;
        upd_pred_taken_in  = 1'b0;
        upd_pred_target_in = 32'd0;
        #12;
        check("rst_flush", {31'd0, flush_out}, 32'd0);
        check("rst_redirect", redirect_pc_out, 32'd0);
        lookup("rst_lookup", 32'h100, 1'b0, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle_cycle();
        check("idle_flush", {31'd0, flush_out}, 32'd0);

        // BEQ miss taken: allocate with WT and flush to target
        apply_update(32'h100, 3'b000, 1'b0, 1'b1, 32'h140, 1'b0, 32'd0);
        check("beq_alloc_flush", {31'd0, flush_out}, 32'd1);
        check("beq_alloc_redir", redirect_pc_out, 32'h140);
        lookup("beq_alloc_lk", 32'h100, 1'b1, 32'h140);

        // Correct prediction then target mismatch, back to back
        apply_update(32'h100, 3'b000, 1'b0, 1'b1, 32'h140, 1'b1, 32'h140);
        check("beq_hit_ok_flush", {31'd0, flush_out}, 32'd0);
        apply_update(32'h100, 3'b000, 1'b0, 1'b1, 32'h140, 1'b1, 32'h180);
        check("beq_tgt_flush", {31'd0, flush_out}, 32'd1);
        check("beq_tgt_redir", redirect_pc_out, 32'h140);
        apply_update(32'h100, 3'b000, 1'b0, 1'b1, 32'h140, 1'b1, 32'h140);
        check("beq_deassert", {31'd0, flush_out}, 32'd0);
        // ST -> WT on not-taken: still predicted taken
        apply_update(32'h100, 3'b000, 1'b0, 1'b0, 32'h140, 1'b1, 32'h140);
        check("beq_nt_flush", {31'd0, flush_out}, 32'd1);
        check("beq_nt_redir", redirect_pc_out, 32'h104);
        lookup("beq_wt_lk", 32'h100, 1'b1, 32'h140);
        // WT -> WNT: hit keeps target but predicts not taken
        apply_update(32'h100, 3'b000, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0);
        check("beq_wnt_flush", {31'd0, flush_out}, 32'd0);
        lookup("beq_wnt_lk", 32'h100, 1'b0, 32'h140);
        // WNT -> WT again
        apply_update(32'h100, 3'b000, 1'b0, 1'b1, 32'h140, 1'b0, 32'h0);
        check("beq_back_flush", {31'd0, flush_out}, 32'd1);
        lookup("beq_back_lk", 32'h100, 1'b1, 32'h140);

        // BLTU not taken, miss: no flush, no allocation
        apply_update(32'h200, 3'b110, 1'b0, 1'b0, 32'h280, 1'b0, 32'h0);
        check("bltu_flush", {31'd0, flush_out}, 32'd0);
        idle_cycle();
        lookup("bltu_lk", 32'h200, 1'b0, 32'd0);
        lookup("bltu_other_lk", 32'h100, 1'b1, 32'h140);

        // Direction decode for the remaining funct3 codes
        apply_update(32'h304, 3'b101, 1'b0, 1'b0, 32'h400, 1'b0, 32'h0);
        check("bge_flush", {31'd0, flush_out}, 32'd1);
        check("bge_redir", redirect_pc_out, 32'h400);
        apply_update(32'h308, 3'b001, 1'b1, 1'b0, 32'h500, 1'b1, 32'h500);
        check("bne_flush", {31'd0, flush_out}, 32'd0);
        apply_update(32'h30C, 3'b100, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10);
        check("blt_flush", {31'd0, flush_out}, 32'd0);
        apply_update(32'h310, 3'b111, 1'b1, 1'b0, 32'h600, 1'b1, 32'h600);
        check("bgeu_flush", {31'd0, flush_out}, 32'd1);
        check("bgeu_redir", redirect_pc_out, 32'h314);
        apply_update(32'hFFFF_FFFC, 3'b000, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
        check("wrap_flush", {31'd0, flush_out}, 32'd1);
        check("wrap_redir", redirect_pc_out, 32'h0);
        idle_cycle();
        lookup("bge_lk", 32'h304, 1'b1, 32'h400);
        lookup("bne_lk", 32'h308, 1'b1, 32'h500);
        lookup("wrap_lk", 32'hFFFF_FFFC, 1'b0, 32'd0);

        // Aliasing: same index, different tag overwrites the entry
        apply_update(32'h200, 3'b000, 1'b0, 1'b1, 32'h240, 1'b0, 32'h0);
        check("alias_flush", {31'd0, flush_out}, 32'd1);
        check("alias_redir", redirect_pc_out, 32'h240);
        lookup("alias_old_lk", 32'h100, 1'b0, 32'd0);
        lookup("alias_new_lk", 32'h200, 1'b1, 32'h240);

        // Illegal funct3 must be ignored completely
        apply_update(32'h200, 3'b010, 1'b0, 1'b0, 32'h240, 1'b1, 32'h240);
        check("f3_010_flush", {31'd0, flush_out}, 32'd0);
        apply_update(32'h600, 3'b011, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
        check("f3_011_flush", {31'd0, flush_out}, 32'd0);
        idle_cycle();
        lookup("f3_011_lk", 32'h600, 1'b0, 32'd0);
        lookup("f3_010_lk", 32'h200, 1'b1, 32'h240);

        // Asynchronous reset drops a pending flush and invalidates the table
        apply_update(32'h200, 3'b000, 1'b0, 1'b0, 32'h240, 1'b1, 32'h240);
        check("pre_rst_flush", {31'd0, flush_out}, 32'd1);
        upd_valid_in = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check("mid_rst_flush", {31'd0, flush_out}, 32'd0);
        check("mid_rst_redir", redirect_pc_out, 32'd0);
        lookup("mid_rst_lk", 32'h200, 1'b0, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle_cycle();
        lookup("post_rst_lk", 32'h304, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
